// File: rtl/sync_debounce_edge_pkg.sv
// sync_debounce_edge_pkg: state encodings shared by the input-conditioning blocks.
package sync_debounce_edge_pkg;
  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_WAIT_HI   = 2'b01,
    ST_STABLE_HI = 2'b11,
    ST_WAIT_LO   = 2'b10
  } state_e;
endpackage

// File: rtl/sync_debounce_edge_sync_chain.sv
// sync_chain: N-flop synchronizer shift register with async active-high reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], din};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end
  assign dout = sync_q[STAGES-1];
endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: synchronize, debounce and edge-detect an asynchronous level.
module sync_debounce_edge
  import sync_debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);
  logic             sync_q, same;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (sync_q)
  );

  assign busy = (state_q == ST_WAIT_HI) | (state_q == ST_WAIT_LO);
  assign same = (sync_q == dout_q);

  // dout_q always equals the level of the current stable/waiting-from state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!en) begin
      state_d = dout_q ? ST_STABLE_HI : ST_STABLE_LO;
      cnt_d   = '0;
    end else if (!busy) begin
      state_d = same ? state_q : (dout_q ? ST_WAIT_LO : ST_WAIT_HI);
      cnt_d   = same ? '0 : CNT_W'(1);
    end else if (same) begin
      state_d = dout_q ? ST_STABLE_HI : ST_STABLE_LO;
      cnt_d   = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      state_d = dout_q ? ST_STABLE_LO : ST_STABLE_HI;
      cnt_d   = '0;
      dout_d  = ~dout_q;
      rise_d  = ~dout_q;
      fall_d  = dout_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STABLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule
